instr_fetch: RTL and testbench

Instruction fetch sequencer for the 9-bit, 3-bit-opcode core. It issues reads to a synchronous instruction ROM, holds each returned word stable for the control decoder under a valid/ready handshake, and advances the program counter sequentially or to a branch target resolved downstream. It sits between instruction memory and the opcode decoder/execute stage and produces the stream that the decoder consumes.

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads a synchronous ROM, presents each word to the
// decoder under a valid/ready handshake and steps the PC sequentially or to a branch target.
module instr_fetch #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic [PC_W-1:0]    last_addr,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               busy,
  output logic               done
);

  // Handshake: instr/instr_pc are held while instr_valid=1; a transfer (accept)
  // happens on any rising edge where instr_valid & instr_ready. branch_taken and
  // branch_target are only looked at on that accept edge.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_VALID = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   last;
  logic              start_go;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_go    = 1'b0;
    accept      = 1'b0;
    imem_rd     = 1'b0;
    instr_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_go  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_rd   = 1'b1;
        busy      = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        busy      = 1'b1;
        state_nxt = S_VALID;
      end
      S_VALID: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
        if (instr_ready) begin
          accept = 1'b1;
          // A taken branch wins even on the final instruction.
          if (!branch_taken && (instr_pc == last)) state_nxt = S_DONE;
          else                                     state_nxt = S_FETCH;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          start_go  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // pc only moves on entry to FETCH, so it doubles as the registered ROM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      last <= '0;
    end else if (start_go) begin
      pc   <= start_addr;
      last <= last_addr;
    end else if (accept && branch_taken) begin
      pc   <= branch_target;
    end else if (accept && (state_nxt == S_FETCH)) begin
      pc   <= pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (state == S_LATCH) begin
      instr    <= imem_data;
      instr_pc <= pc;
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural sync ROM (ROM[i]=i), hand-computed
// expectations for sequential run, backpressure, branch, wrap, reset and restart.
module tb_instr_fetch;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [PC_W-1:0]    start_addr;
  logic [PC_W-1:0]    last_addr;
  logic               imem_rd;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               busy;
  logic               done;

  int n_cmp;
  int n_bad;
  int rd_count;

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .last_addr    (last_addr),
    .imem_rd      (imem_rd),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .busy         (busy),
    .done         (done)
  );

  // Clock / reset-free clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model: word = low 9 address bits; junk when not read so a
  // capture outside LATCH shows up.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= imem_addr[INSTR_W-1:0];
    else         imem_data <= 9'h1AA;
  end

  always @(posedge clk) begin
    if (rst_n && imem_rd) rd_count++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PC_W-1:0] sa, input logic [PC_W-1:0] la);
    start      = 1'b1;
    start_addr = sa;
    last_addr  = la;
    step();
    start      = 1'b0;
  endtask

  // Waits (bounded) for instr_valid; returns edges waited.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    check_val({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic accept(input logic br, input logic [PC_W-1:0] tgt);
    instr_ready   = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    step();
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
  endtask

  initial begin
    int n;
    logic [PC_W-1:0] wrap_pc [3];
    n_cmp = 0; n_bad = 0; rd_count = 0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; last_addr = '0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) step();
    check_val("rst_imem_rd", 32'(imem_rd), 32'd0);
    check_val("rst_imem_addr", 32'(imem_addr), 32'd0);
    check_val("rst_instr", 32'(instr), 32'd0);
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_busy_done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    step();

    // Sequential run 0x005..0x007 with ready held high
    rd_count = 0;
    instr_ready = 1'b1;
    do_start(10'h005, 10'h007);
    check_val("seq_fetch_rd", 32'(imem_rd), 32'd1);
    check_val("seq_fetch_addr", 32'(imem_addr), 32'h005);
    for (int i = 5; i <= 7; i++) begin
      wait_valid("seq", n);
      check_val("seq_latency", 32'(n), 32'd2);
      check_val("seq_instr", 32'(instr), 32'(i));
      check_val("seq_pc", 32'(instr_pc), 32'(i));
      step();
    end
    instr_ready = 1'b0;
    check_val("seq_done", {30'd0, busy, done}, 32'd1);
    check_val("seq_valid_low", 32'(instr_valid), 32'd0);
    check_val("seq_instr_kept", 32'(instr), 32'h007);
    check_val("seq_rd_count", 32'(rd_count), 32'd3);

    // Backpressure at 0x00F, then branch at 0x010, then branch on last (0x020)
    do_start(10'h00F, 10'h020);
    wait_valid("bp", n);
    rd_count = 0;
    for (int i = 0; i < 5; i++) begin
      branch_taken  = (i % 2 == 0);
      branch_target = 10'h020;
      step();
      check_val("bp_valid", 32'(instr_valid), 32'd1);
      check_val("bp_instr", 32'(instr), 32'h00F);
      check_val("bp_pc", 32'(instr_pc), 32'h00F);
    end
    branch_taken = 1'b0;
    check_val("bp_no_rd", 32'(rd_count), 32'd0);
    accept(1'b0, 10'h000);
    check_val("bp_next_addr", 32'(imem_addr), 32'h010);
    wait_valid("bp2", n);
    check_val("bp_next_pc", 32'(instr_pc), 32'h010);
    accept(1'b1, 10'h020);
    check_val("br_addr", 32'(imem_addr), 32'h020);
    check_val("br_rd", 32'(imem_rd), 32'd1);
    wait_valid("br", n);
    check_val("br_pc", 32'(instr_pc), 32'h020);
    check_val("br_instr", 32'(instr), 32'h020);
    accept(1'b1, 10'h020);
    check_val("br_last_done", 32'(done), 32'd0);
    check_val("br_last_busy", 32'(busy), 32'd1);
    wait_valid("br2", n);
    check_val("br_last_pc", 32'(instr_pc), 32'h020);
    accept(1'b0, 10'h000);
    check_val("br_final_done", 32'(done), 32'd1);

    // Wrap 0x3FF -> 0x000 -> 0x001
    wrap_pc[0] = 10'h3FF; wrap_pc[1] = 10'h000; wrap_pc[2] = 10'h001;
    rd_count = 0;
    do_start(10'h3FF, 10'h001);
    for (int i = 0; i < 3; i++) begin
      check_val("wrap_addr", 32'(imem_addr), 32'(wrap_pc[i]));
      wait_valid("wrap", n);
      check_val("wrap_pc", 32'(instr_pc), 32'(wrap_pc[i]));
      check_val("wrap_instr", 32'(instr), 32'(wrap_pc[i][INSTR_W-1:0]));
      accept(1'b0, 10'h000);
    end
    check_val("wrap_done", 32'(done), 32'd1);
    check_val("wrap_rd_count", 32'(rd_count), 32'd3);

    // Asynchronous reset during LATCH
    do_start(10'h040, 10'h041);
    step();
    rst_n = 1'b0;
    #1;
    check_val("arst_rd", 32'(imem_rd), 32'd0);
    check_val("arst_addr", 32'(imem_addr), 32'd0);
    check_val("arst_instr", 32'(instr), 32'd0);
    check_val("arst_pc", 32'(instr_pc), 32'd0);
    check_val("arst_flags", {29'd0, instr_valid, busy, done}, 32'd0);
    rd_count = 0;
    step();
    rst_n = 1'b1;
    step();
    check_val("arst_idle", {30'd0, busy, done}, 32'd0);
    check_val("arst_no_rd", 32'(rd_count), 32'd0);
    do_start(10'h000, 10'h000);
    check_val("arst_run_addr", 32'(imem_addr), 32'h000);
    wait_valid("arst_run", n);
    check_val("arst_run_lat", 32'(n), 32'd2);
    check_val("arst_run_pc", 32'(instr_pc), 32'h000);
    accept(1'b0, 10'h000);
    check_val("arst_run_done", 32'(done), 32'd1);

    // Restart from DONE at 0x100; start pulsed in VALID is ignored
    do_start(10'h100, 10'h101);
    check_val("rs_done_drop", 32'(done), 32'd0);
    check_val("rs_addr", 32'(imem_addr), 32'h100);
    wait_valid("rs", n);
    start = 1'b1; start_addr = 10'h200; last_addr = 10'h200;
    step();
    start = 1'b0;
    check_val("rs_ign_valid", 32'(instr_valid), 32'd1);
    check_val("rs_ign_pc", 32'(instr_pc), 32'h100);
    accept(1'b0, 10'h000);
    check_val("rs_ign_addr", 32'(imem_addr), 32'h101);
    wait_valid("rs2", n);
    check_val("rs2_pc", 32'(instr_pc), 32'h101);
    accept(1'b0, 10'h000);
    check_val("rs_final_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
